// File: rtl/program_loader_pkg.sv
// Shared types and sizing for the SUBLEQ boot loader.
package program_loader_pkg;

   localparam int WORD_SIZE      = 16;
   localparam int BYTES_PER_WORD = WORD_SIZE / 8;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      PAYLOAD,
      WRITE,
      CHECK,
      DONE,
      ERROR
   } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in, memory write port out; slave is the loader side.
interface program_loader_if
   import program_loader_pkg::*;
#(
   parameter int WORD_SIZE = program_loader_pkg::WORD_SIZE,
   parameter int ADDR_W    = 8
);
   logic [7:0]           in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [ADDR_W-1:0]    mem_addr;
   logic [WORD_SIZE-1:0] mem_data;
   logic                 mem_write;

   modport master (
      output in_data, in_valid,
      input  in_ready, mem_addr, mem_data, mem_write
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_addr, mem_data, mem_write
   );
endinterface

// File: rtl/program_loader_byte_packer.sv
// Shifts accepted bytes MSB-first into a word; pulses word_valid the cycle after the last byte.
module program_loader_byte_packer
   import program_loader_pkg::*;
#(
   parameter int WORD_SIZE = program_loader_pkg::WORD_SIZE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 byte_valid,
   input  logic [7:0]           byte_in,
   output logic [WORD_SIZE-1:0] word,
   output logic                 word_done,
   output logic                 word_valid
);
   localparam int BPW   = WORD_SIZE / 8;
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

   logic [WORD_SIZE-1:0] word_q, word_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 word_valid_q, word_valid_d;

   always_comb begin
      word_d       = word_q;
      cnt_d        = cnt_q;
      word_valid_d = 1'b0;
      word_done    = byte_valid && (cnt_q == CNT_W'(BPW - 1));
      if (clr) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (byte_valid) begin
         word_d       = (word_q << 8) | WORD_SIZE'(byte_in);
         cnt_d        = word_done ? '0 : cnt_q + 1'b1;
         word_valid_d = word_done;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_q       <= '0;
         cnt_q        <= '0;
         word_valid_q <= 1'b0;
      end else begin
         word_q       <= word_d;
         cnt_q        <= cnt_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign word       = word_q;
   assign word_valid = word_valid_q;
endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a length-prefixed, XOR-checked byte frame into program memory, then releases the core.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int  WORD_SIZE = program_loader_pkg::WORD_SIZE,
   parameter int  MEM_DEPTH = 256,
   localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   program_loader_if.slave   bus,
   output logic              cpu_run,
   output logic              busy,
   output logic              error,
   output logic [15:0]       words_loaded
);
   loader_state_t state_q, state_d;
   logic [15:0]   n_q, n_d;
   logic [7:0]    chk_q, chk_d;
   logic [15:0]   wl_q, wl_d;
   logic          in_ready_q, in_ready_d;
   logic          busy_q, busy_d;
   logic          error_q, error_d;
   logic          cpu_run_q, cpu_run_d;
   logic          xfer, pack_clr, pack_valid, word_done, word_valid;
   logic [WORD_SIZE-1:0] packed_word;
   logic [15:0]   n_full;

   assign xfer   = bus.in_valid && in_ready_q;
   assign n_full = {n_q[15:8], bus.in_data};

   program_loader_byte_packer #(.WORD_SIZE(WORD_SIZE)) u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (pack_clr),
      .byte_valid (pack_valid),
      .byte_in    (bus.in_data),
      .word       (packed_word),
      .word_done  (word_done),
      .word_valid (word_valid)
   );

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      chk_d      = chk_q;
      wl_d       = wl_q;
      error_d    = error_q;
      cpu_run_d  = cpu_run_q;
      pack_clr   = 1'b0;
      pack_valid = 1'b0;
      unique case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d   = LEN_HI;
               error_d   = 1'b0;
               cpu_run_d = 1'b0;
               wl_d      = '0;
               chk_d     = '0;
               pack_clr  = 1'b1;
            end
         end
         LEN_HI: if (xfer) begin
            n_d[15:8] = bus.in_data;
            chk_d     = chk_q ^ bus.in_data;
            state_d   = LEN_LO;
         end
         LEN_LO: if (xfer) begin
            n_d   = n_full;
            chk_d = chk_q ^ bus.in_data;
            // Oversize frames are refused before any word reaches memory.
            if (n_full > 16'(MEM_DEPTH)) begin
               state_d = ERROR;
               error_d = 1'b1;
            end else if (n_full == 16'd0) begin
               state_d = CHECK;
            end else begin
               state_d = PAYLOAD;
            end
         end
         PAYLOAD: if (xfer) begin
            pack_valid = 1'b1;
            chk_d      = chk_q ^ bus.in_data;
            if (word_done) state_d = WRITE;
         end
         WRITE: begin
            wl_d    = wl_q + 16'd1;
            state_d = (wl_q + 16'd1 == n_q) ? CHECK : PAYLOAD;
         end
         CHECK: if (xfer) begin
            if (bus.in_data == chk_q) begin
               state_d   = DONE;
               cpu_run_d = 1'b1;
            end else begin
               state_d = ERROR;
               error_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                   (state_d == PAYLOAD) || (state_d == CHECK);
      busy_d     = in_ready_d || (state_d == WRITE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         n_q        <= '0;
         chk_q      <= '0;
         wl_q       <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
         cpu_run_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         chk_q      <= chk_d;
         wl_q       <= wl_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         error_q    <= error_d;
         cpu_run_q  <= cpu_run_d;
      end
   end

   // During WRITE the counter still holds the index of the word being stored.
   assign bus.mem_addr  = wl_q[ADDR_W-1:0];
   assign bus.mem_data  = packed_word;
   assign bus.mem_write = word_valid;
   assign bus.in_ready  = in_ready_q;
   assign cpu_run       = cpu_run_q;
   assign busy          = busy_q;
   assign error         = error_q;
   assign words_loaded  = wl_q;
endmodule
